com_bus_arbiter_i: RTL and testbench

Arbiter for the shared instruction-side common bus (Address_Com / Data_Bus_Com / Data_in_Bus) used by the four per-core instruction caches. It takes each cache's processor bus request and snoop/writeback request, issues exactly one registered grant at a time, and holds that grant until the owner releases its request. Snoop traffic has priority over processor fills, and each class is round-robin fair among the four cores. A one-cycle turnaround separates consecutive owners so that no two caches drive the tri-stated common bus in the same cycle.

---
 rtl/com_bus_arbiter_i_pkg.sv | 24 ++
 rtl/com_bus_arbiter_i_if.sv | 34 +++
 rtl/com_bus_arbiter_i_rr_pick_4.sv | 27 ++
 rtl/com_bus_arbiter_i.sv | 159 +++++++++++++++
 tb/tb_com_bus_arbiter_i.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/com_bus_arbiter_i_pkg.sv
// Shared cache definitions for the instruction-side common bus arbiter:
// core count, owner-id width, FSM state encoding and a one-hot helper.
package com_bus_arbiter_i_pkg;

    localparam int unsigned NUM_CORES = 4;
    localparam int unsigned ID_W      = 2;

    typedef logic [ID_W-1:0] core_id_t;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StGntSnoop = 2'd1,
        StGntProc  = 2'd2,
        StTurn     = 2'd3
    } arb_state_e;

    function automatic logic [NUM_CORES-1:0] id_to_onehot(core_id_t id);
        logic [NUM_CORES-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/com_bus_arbiter_i_if.sv
// Request/grant bundle between the four instruction caches and the common-bus
// arbiter. The arbiter uses the master modport, the caches the slave modport.
interface com_bus_arbiter_i_if;
    import com_bus_arbiter_i_pkg::*;

    logic [NUM_CORES-1:0] Com_Bus_Req_proc;
    logic [NUM_CORES-1:0] Com_Bus_Req_snoop;
    logic [NUM_CORES-1:0] Com_Bus_Gnt_proc;
    logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop;
    core_id_t             Gnt_id;
    logic                 Bus_busy;
    logic                 Bus_timeout;

    modport master (
        input  Com_Bus_Req_proc,
        input  Com_Bus_Req_snoop,
        output Com_Bus_Gnt_proc,
        output Com_Bus_Gnt_snoop,
        output Gnt_id,
        output Bus_busy,
        output Bus_timeout
    );

    modport slave (
        output Com_Bus_Req_proc,
        output Com_Bus_Req_snoop,
        input  Com_Bus_Gnt_proc,
        input  Com_Bus_Gnt_snoop,
        input  Gnt_id,
        input  Bus_busy,
        input  Bus_timeout
    );

endinterface

// File: rtl/com_bus_arbiter_i_rr_pick_4.sv
// Combinational 4-way round-robin picker: first set request at or after the
// pointer, wrapping 3->0.
module rr_pick_4
    import com_bus_arbiter_i_pkg::*;
(
    input  logic [NUM_CORES-1:0] req_i,
    input  core_id_t             ptr_i,
    output logic                 valid_o,
    output core_id_t             winner_o
);

    core_id_t idx;

    always_comb begin
        valid_o  = |req_i;
        winner_o = ptr_i;
        idx      = '0;
        // Walk from the farthest offset down so the nearest request wins last.
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = ptr_i + core_id_t'(k);
            if (req_i[idx]) begin
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/com_bus_arbiter_i.sv
// Common-bus arbiter for the four instruction caches: snoop over proc priority,
// per-class round robin, one-cycle turnaround. Forced release: COM_BUS_ARB_TIMEOUT_EN.
module com_bus_arbiter_i
    import com_bus_arbiter_i_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic                 clk,
    input logic                 rst,
    com_bus_arbiter_i_if.master bus_io
);

    if (NUM_CORES != 4) begin : g_core_check
        $error("com_bus_arbiter_i is built for exactly 4 cores");
    end
    if (MAX_HOLD < 2) begin : g_hold_check
        $error("com_bus_arbiter_i needs MAX_HOLD >= 2");
    end

    arb_state_e           state_q, state_d;
    core_id_t             ptr_snoop_q, ptr_snoop_d;
    core_id_t             ptr_proc_q, ptr_proc_d;
    core_id_t             owner_q, owner_d;
    logic [NUM_CORES-1:0] gnt_snoop_q, gnt_snoop_d;
    logic [NUM_CORES-1:0] gnt_proc_q, gnt_proc_d;

    logic                 snoop_vld, proc_vld;
    core_id_t             snoop_win, proc_win;
    logic                 hold_expired;

    rr_pick_4 u_pick_snoop (
        .req_i    (bus_io.Com_Bus_Req_snoop),
        .ptr_i    (ptr_snoop_q),
        .valid_o  (snoop_vld),
        .winner_o (snoop_win)
    );

    rr_pick_4 u_pick_proc (
        .req_i    (bus_io.Com_Bus_Req_proc),
        .ptr_i    (ptr_proc_q),
        .valid_o  (proc_vld),
        .winner_o (proc_win)
    );

`ifdef COM_BUS_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

    logic [CntW-1:0]      hold_cnt_q, hold_cnt_d;
    logic                 timeout_q;
    logic                 granted;
    logic [NUM_CORES-1:0] owner_oh;
    logic                 other_snoop_req, other_proc_req;

    assign granted  = (state_q == StGntSnoop) || (state_q == StGntProc);
    assign owner_oh = id_to_onehot(owner_q);

    // Competing demand excludes only the owner's own same-class request.
    assign other_snoop_req = (state_q == StGntSnoop) ?
                             |(bus_io.Com_Bus_Req_snoop & ~owner_oh) : |bus_io.Com_Bus_Req_snoop;
    assign other_proc_req  = (state_q == StGntProc) ?
                             |(bus_io.Com_Bus_Req_proc & ~owner_oh) : |bus_io.Com_Bus_Req_proc;

    assign hold_expired = granted && (hold_cnt_q == HoldLast) &&
                          (other_snoop_req || other_proc_req);

    always_comb begin
        hold_cnt_d = '0;
        if (granted) begin
            hold_cnt_d = (hold_cnt_q == HoldLast) ? hold_cnt_q : hold_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= hold_expired;
        end
    end

    assign bus_io.Bus_timeout = timeout_q;
`else
    assign hold_expired       = 1'b0;
    assign bus_io.Bus_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_snoop_d = ptr_snoop_q;
        ptr_proc_d  = ptr_proc_q;
        owner_d     = owner_q;
        gnt_snoop_d = gnt_snoop_q;
        gnt_proc_d  = gnt_proc_q;

        case (state_q)
            // TURN arbitrates like IDLE so the gap between owners is one cycle.
            StIdle, StTurn: begin
                gnt_snoop_d = '0;
                gnt_proc_d  = '0;
                state_d     = StIdle;
                if (snoop_vld) begin
                    state_d     = StGntSnoop;
                    owner_d     = snoop_win;
                    gnt_snoop_d = id_to_onehot(snoop_win);
                end else if (proc_vld) begin
                    state_d    = StGntProc;
                    owner_d    = proc_win;
                    gnt_proc_d = id_to_onehot(proc_win);
                end
            end
            StGntSnoop: begin
                if (!bus_io.Com_Bus_Req_snoop[owner_q] || hold_expired) begin
                    state_d     = StTurn;
                    gnt_snoop_d = '0;
                    ptr_snoop_d = owner_q + core_id_t'(1);
                end
            end
            StGntProc: begin
                if (!bus_io.Com_Bus_Req_proc[owner_q] || hold_expired) begin
                    state_d    = StTurn;
                    gnt_proc_d = '0;
                    ptr_proc_d = owner_q + core_id_t'(1);
                end
            end
            default: begin
                state_d     = StIdle;
                gnt_snoop_d = '0;
                gnt_proc_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_snoop_q <= '0;
            ptr_proc_q  <= '0;
            owner_q     <= '0;
            gnt_snoop_q <= '0;
            gnt_proc_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_snoop_q <= ptr_snoop_d;
            ptr_proc_q  <= ptr_proc_d;
            owner_q     <= owner_d;
            gnt_snoop_q <= gnt_snoop_d;
            gnt_proc_q  <= gnt_proc_d;
        end
    end

    assign bus_io.Com_Bus_Gnt_snoop = gnt_snoop_q;
    assign bus_io.Com_Bus_Gnt_proc  = gnt_proc_q;
    assign bus_io.Gnt_id            = owner_q;
    assign bus_io.Bus_busy          = |{gnt_snoop_q, gnt_proc_q};

endmodule

// File: tb/tb_com_bus_arbiter_i.sv
// Directed bench for com_bus_arbiter_i; expected grant owners are queued when
// requests are driven and compared when grants appear.
module tb_com_bus_arbiter_i;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    com_bus_arbiter_i_if bus ();

    com_bus_arbiter_i #(
        .MAX_HOLD (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct packed {
        logic       snoop;
        logic [1:0] id;
    } gnt_t;

    gnt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot", 32'($countones({bus.Com_Bus_Gnt_snoop, bus.Com_Bus_Gnt_proc}) <= 1), 1);
    endtask

    task automatic push_exp(input logic s, input logic [1:0] id);
        gnt_t e;
        e.snoop = s;
        e.id    = id;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        gnt_t       e;
        logic [3:0] oh;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e.id;
            check({tag, "_gnt_snoop"}, bus.Com_Bus_Gnt_snoop, e.snoop ? oh : 4'b0000);
            check({tag, "_gnt_proc"}, bus.Com_Bus_Gnt_proc, e.snoop ? 4'b0000 : oh);
            check({tag, "_gnt_id"}, bus.Gnt_id, e.id);
            check({tag, "_busy"}, bus.Bus_busy, 1);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt_snoop"}, bus.Com_Bus_Gnt_snoop, 0);
        check({tag, "_gnt_proc"}, bus.Com_Bus_Gnt_proc, 0);
        check({tag, "_busy"}, bus.Bus_busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst                   = 1'b1;
        bus.Com_Bus_Req_proc  = 4'b0000;
        bus.Com_Bus_Req_snoop = 4'b0000;

        // Reset values.
        tick();
        tick();
        check_idle("reset");
        check("reset_timeout", bus.Bus_timeout, 0);
        check("reset_id", bus.Gnt_id, 0);
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Single proc request: one cycle latency, release, TURN, IDLE.
        bus.Com_Bus_Req_proc = 4'b0001;
        push_exp(1'b0, 2'd0);
        tick();
        pop_check("single");
        tick();
        check("single_hold", bus.Com_Bus_Gnt_proc, 4'b0001);
        bus.Com_Bus_Req_proc = 4'b0000;
        tick();
        check_idle("single_turn");
        tick();
        check_idle("single_idle");

        // Round robin among four proc requesters, one idle cycle between tenures.
        do_reset();
        bus.Com_Bus_Req_proc = 4'b1111;
        for (int k = 0; k < 5; k++) push_exp(1'b0, 2'(k % 4));
        tick();
        for (int k = 0; k < 5; k++) begin
            pop_check("rr");
            tick();
            tick();
            check("rr_hold", bus.Com_Bus_Gnt_proc, 4'b0001 << (k % 4));
            bus.Com_Bus_Req_proc[k % 4] = 1'b0;
            tick();
            check_idle("rr_gap");
            if (k == 4) bus.Com_Bus_Req_proc = 4'b0000;
            else bus.Com_Bus_Req_proc[k % 4] = 1'b1;
            tick();
        end
        check_idle("rr_done");
        tick();

        // Snoop 3 and proc 1 together: snoop first, proc two cycles after release.
        bus.Com_Bus_Req_proc  = 4'b0010;
        bus.Com_Bus_Req_snoop = 4'b1000;
        push_exp(1'b1, 2'd3);
        push_exp(1'b0, 2'd1);
        tick();
        pop_check("prio_snoop");
        tick();
        check("prio_snoop_hold", bus.Com_Bus_Gnt_snoop, 4'b1000);
        bus.Com_Bus_Req_snoop = 4'b0000;
        tick();
        check_idle("prio_turn");
        tick();
        pop_check("prio_proc");
        bus.Com_Bus_Req_proc = 4'b0000;
        tick();
        check_idle("prio_release");
        tick();

        // Same cache raises both classes; the proc request does not extend the snoop tenure.
        bus.Com_Bus_Req_proc  = 4'b0001;
        bus.Com_Bus_Req_snoop = 4'b0001;
        push_exp(1'b1, 2'd0);
        push_exp(1'b0, 2'd0);
        tick();
        pop_check("same_snoop");
        bus.Com_Bus_Req_snoop = 4'b0000;
        tick();
        check_idle("same_turn");
        tick();
        pop_check("same_proc");
        bus.Com_Bus_Req_proc = 4'b0000;
        tick();
        check_idle("same_release");
        tick();

`ifdef COM_BUS_ARB_TIMEOUT_EN
        // Owner 2 holds; cache 0 waits; forced release after 16 granted cycles.
        do_reset();
        bus.Com_Bus_Req_proc = 4'b0100;
        push_exp(1'b0, 2'd2);
        tick();
        pop_check("to_owner");
        bus.Com_Bus_Req_proc = 4'b0101;
        for (int k = 1; k < 16; k++) begin
            tick();
            check("to_held", bus.Com_Bus_Gnt_proc, 4'b0100);
            check("to_no_pulse", bus.Bus_timeout, 0);
        end
        tick();
        check_idle("to_revoke");
        check("to_pulse", bus.Bus_timeout, 1);
        push_exp(1'b0, 2'd0);
        tick();
        pop_check("to_next");
        check("to_pulse_end", bus.Bus_timeout, 0);
        bus.Com_Bus_Req_proc = 4'b0000;
        tick();
        tick();
`endif

        // Reset mid-tenure: grants drop, pointers return to 0.
        bus.Com_Bus_Req_snoop = 4'b0100;
        push_exp(1'b1, 2'd2);
        tick();
        pop_check("rst_owner");
        bus.Com_Bus_Req_snoop = 4'b0101;
        rst = 1'b1;
        tick();
        check_idle("rst_drop");
        check("rst_id", bus.Gnt_id, 0);
        rst = 1'b0;
        push_exp(1'b1, 2'd0);
        tick();
        pop_check("rst_regrant");
        bus.Com_Bus_Req_snoop = 4'b0000;
        tick();
        check_idle("rst_release");
        tick();

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
